// File: rtl/serv_mem_seq_pkg.sv
// Shared types and helpers for the serial-core load/store sequencer.
// The optional bus timeout is enabled with SERV_MEM_SEQ_TIMEOUT_EN.
package serv_mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int TMO_W = 16;

  // Size code 3 falls through to word in both helpers.
  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_B:  byte_sel = 4'b0001 << lsb;
      SIZE_H:  byte_sel = 4'b0011 << {lsb[1], 1'b0};
      default: byte_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = lsb[0];
      default: misaligned = (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/serv_mem_seq_tmo.sv
// Bus timeout down-counter; expired flags the cycle whose decrement would reach zero.
// Only instantiated when SERV_MEM_SEQ_TIMEOUT_EN is defined.
module serv_mem_seq_tmo
  import serv_mem_seq_pkg::*;
#(
  parameter logic [TMO_W-1:0] INIT = 16'd255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= INIT;
    end else if (load) begin
      cnt <= INIT;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && (cnt == TMO_W'(1));

endmodule

// File: rtl/serv_mem_seq.sv
// Load/store sequencer: bus handshake, byte selects, misalignment trap, load strobe.
// Optional bus abort enabled by defining SERV_MEM_SEQ_TIMEOUT_EN.
//   state   | meaning
//   ST_IDLE | waiting for i_req; misaligned requests trap here
//   ST_BUS  | o_wb_cyc asserted, waiting for i_wb_ack (or timeout)
//   ST_DONE | ack seen; o_load pulsing for loads, o_done follows
module serv_mem_seq
  import serv_mem_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [1:0] i_size,
  input  logic [1:0] i_lsb,
  input  logic [1:0] i_cnt_byte,
  output logic       o_wb_cyc,
  output logic       o_wb_we,
  output logic [3:0] o_wb_sel,
  input  logic       i_wb_ack,
  output logic       o_load,
  output logic       o_byte_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_misalign,
  output logic       o_timeout
);

  state_t     state;
  logic [1:0] size;
  logic       tmo_expired;
  logic       timeout_q;

`ifdef SERV_MEM_SEQ_TIMEOUT_EN
  serv_mem_seq_tmo #(
    .INIT(TMO_W'(TIMEOUT_CYCLES))
  ) u_tmo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .load   (state != ST_BUS),
    .enable ((state == ST_BUS) && !i_wb_ack),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      size       <= SIZE_B;
      o_wb_cyc   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_sel   <= 4'b0000;
      o_load     <= 1'b0;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      o_load     <= 1'b0;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            o_wb_we <= i_we;
            size    <= i_size;
            if (misaligned(i_size, i_lsb)) begin
              o_misalign <= 1'b1;
            end else begin
              o_wb_sel <= byte_sel(i_size, i_lsb);
              o_wb_cyc <= 1'b1;
              state    <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          // Ack wins over a simultaneous expiry.
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_load   <= !o_wb_we;
            state    <= ST_DONE;
          end else if (tmo_expired) begin
            o_wb_cyc  <= 1'b0;
            timeout_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERV_MEM_SEQ_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_busy = (state != ST_IDLE);

  always_comb begin
    case (size)
      SIZE_B:  o_byte_valid = (i_cnt_byte == 2'd0);
      SIZE_H:  o_byte_valid = (i_cnt_byte <= 2'd1);
      default: o_byte_valid = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serv_mem_seq.sv
// Directed self-checking bench for serv_mem_seq.
module tb_serv_mem_seq;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_req = 1'b0;
  logic       i_we = 1'b0;
  logic [1:0] i_size = 2'd0;
  logic [1:0] i_lsb = 2'd0;
  logic [1:0] i_cnt_byte = 2'd0;
  logic       i_wb_ack = 1'b0;
  logic       o_wb_cyc, o_wb_we, o_load, o_byte_valid, o_busy, o_done, o_misalign, o_timeout;
  logic [3:0] o_wb_sel;

  int checks = 0;
  int failures = 0;

  serv_mem_seq #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_lsb(i_lsb), .i_cnt_byte(i_cnt_byte), .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we),
    .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .o_load(o_load), .o_byte_valid(o_byte_valid),
    .o_busy(o_busy), .o_done(o_done), .o_misalign(o_misalign), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Packs cyc,load,done,misalign,timeout,busy for compact comparisons.
  function automatic logic [5:0] flags();
    return {o_wb_cyc, o_load, o_done, o_misalign, o_timeout, o_busy};
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic [1:0] lsb);
    i_req = 1'b1; i_we = we; i_size = size; i_lsb = lsb;
    tick();
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (flags() !== 6'b000000 || o_wb_sel !== 4'b0000 || o_wb_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_state flags=%b sel=%b we=%b required flags=000000 sel=0000 we=0", flags(), o_wb_sel, o_wb_we);
    end
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    issue(1'b0, 2'd2, 2'd0);
    checks++;
    if (flags() !== 6'b100001 || o_wb_sel !== 4'b1111 || o_wb_we !== 1'b0) begin
      failures++;
      $display("FAIL wload_issue flags=%b sel=%b we=%b required 100001 1111 0", flags(), o_wb_sel, o_wb_we);
    end
    tick(); tick();
    checks++;
    if (flags() !== 6'b100001 || o_wb_sel !== 4'b1111) begin
      failures++;
      $display("FAIL wload_wait flags=%b sel=%b required 100001 1111", flags(), o_wb_sel);
    end
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (flags() !== 6'b010001) begin
      failures++;
      $display("FAIL wload_ack flags=%b required 010001", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b001000) begin
      failures++;
      $display("FAIL wload_done flags=%b required 001000", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b000000) begin
      failures++;
      $display("FAIL wload_idle flags=%b required 000000", flags());
    end
  endtask

  task automatic test_byte_store();
    issue(1'b1, 2'd0, 2'd3);
    checks++;
    if (flags() !== 6'b100001 || o_wb_sel !== 4'b1000 || o_wb_we !== 1'b1) begin
      failures++;
      $display("FAIL bstore_issue flags=%b sel=%b we=%b required 100001 1000 1", flags(), o_wb_sel, o_wb_we);
    end
    for (int c = 0; c < 4; c++) begin
      i_cnt_byte = 2'(c);
      #1;
      checks++;
      if (o_byte_valid !== (c == 0)) begin
        failures++;
        $display("FAIL bstore_bvalid cnt=%0d got=%b required=%b", c, o_byte_valid, (c == 0));
      end
    end
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (flags() !== 6'b000001) begin
      failures++;
      $display("FAIL bstore_ack flags=%b required 000001", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b001000) begin
      failures++;
      $display("FAIL bstore_done flags=%b required 001000", flags());
    end
    tick();
  endtask

  task automatic test_half_load();
    issue(1'b0, 2'd1, 2'd2);
    checks++;
    if (o_wb_sel !== 4'b1100 || o_wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL hload_sel sel=%b cyc=%b required 1100 1", o_wb_sel, o_wb_cyc);
    end
    for (int c = 0; c < 4; c++) begin
      i_cnt_byte = 2'(c);
      #1;
      checks++;
      if (o_byte_valid !== (c <= 1)) begin
        failures++;
        $display("FAIL hload_bvalid cnt=%0d got=%b required=%b", c, o_byte_valid, (c <= 1));
      end
    end
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (o_load !== 1'b1) begin
      failures++;
      $display("FAIL hload_load got=%b required=1", o_load);
    end
    tick(); tick();
  endtask

  task automatic test_misalign(input logic [1:0] size, input logic [1:0] lsb);
    issue(1'b0, size, lsb);
    checks++;
    if (flags() !== 6'b000100) begin
      failures++;
      $display("FAIL misalign_pulse size=%0d lsb=%0d flags=%b required 000100", size, lsb, flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b000000) begin
      failures++;
      $display("FAIL misalign_after size=%0d lsb=%0d flags=%b required 000000", size, lsb, flags());
    end
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b0, 2'd2, 2'd0);
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (flags() !== 6'b000000 || o_wb_sel !== 4'b0000) begin
      failures++;
      $display("FAIL rst_midbus flags=%b sel=%b required 000000 0000", flags(), o_wb_sel);
    end
    #1 i_rst = 1'b0;
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (flags() !== 6'b000000) begin
      failures++;
      $display("FAIL rst_late_ack flags=%b required 000000", flags());
    end
    tick();
    checks++;
    if (o_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_done got=%b required=0", o_done);
    end
    issue(1'b0, 2'd0, 2'd1);
    checks++;
    if (o_wb_cyc !== 1'b1 || o_wb_sel !== 4'b0010) begin
      failures++;
      $display("FAIL rst_next_req cyc=%b sel=%b required 1 0010", o_wb_cyc, o_wb_sel);
    end
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (o_load !== 1'b1) begin
      failures++;
      $display("FAIL rst_next_load got=%b required=1", o_load);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 2'd2, 2'd0);
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    tick();
    checks++;
    if (o_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got=%b required=1", o_done);
    end
    issue(1'b0, 2'd0, 2'd2);
    checks++;
    if (o_wb_cyc !== 1'b1 || o_wb_sel !== 4'b0100 || o_wb_we !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second cyc=%b sel=%b we=%b required 1 0100 0", o_wb_cyc, o_wb_sel, o_wb_we);
    end
    i_req = 1'b1; i_size = 2'd2;
    tick();
    i_req = 1'b0;
    checks++;
    if (o_wb_sel !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_req_ignored sel=%b required 0100", o_wb_sel);
    end
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
`ifdef SERV_MEM_SEQ_TIMEOUT_EN
    issue(1'b0, 2'd2, 2'd0);
    tick(); tick(); tick();
    checks++;
    if (flags() !== 6'b100001) begin
      failures++;
      $display("FAIL tmo_wait flags=%b required 100001", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b000010) begin
      failures++;
      $display("FAIL tmo_abort flags=%b required 000010", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b000000) begin
      failures++;
      $display("FAIL tmo_after flags=%b required 000000", flags());
    end
    issue(1'b0, 2'd2, 2'd0);
    tick(); tick(); tick();
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    checks++;
    if (flags() !== 6'b010001) begin
      failures++;
      $display("FAIL tmo_ack_last flags=%b required 010001", flags());
    end
    tick();
    checks++;
    if (flags() !== 6'b001000) begin
      failures++;
      $display("FAIL tmo_ack_done flags=%b required 001000", flags());
    end
    tick();
`else
    issue(1'b0, 2'd2, 2'd0);
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (flags() !== 6'b100001) begin
      failures++;
      $display("FAIL notmo_wait flags=%b required 100001", flags());
    end
    i_wb_ack = 1'b1;
    tick();
    i_wb_ack = 1'b0;
    tick();
    checks++;
    if (o_done !== 1'b1 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL notmo_done done=%b timeout=%b required 1 0", o_done, o_timeout);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_load();
    test_misalign(2'd1, 2'd1);
    test_misalign(2'd2, 2'd2);
    test_reset_mid_bus();
    test_back_to_back();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_mem_seq.md
# serv_mem_seq

Sequencer for the bit-serial core's load/store path. Accepts one memory request per instruction from the decode/state logic, runs the 32-bit bus handshake, generates byte selects and the misalignment trap, pulses the parallel-load strobe into the data buffer register when read data returns, and qualifies the byte lanes shifted back into rd. Sits between the core state machine, the data buffer register and the external data bus.

## Interface
- TIMEOUT_CYCLES, 255, bus cycles allowed between request issue and ack before abort; range 1..65535. Used only when SERV_MEM_SEQ_TIMEOUT_EN is defined.
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  start memory op; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load; sampled with i_req
- i_size  in  2  0 byte, 1 half, 2 word; 3 treated as word
- i_lsb  in  2  address bits [1:0]; sampled with i_req
- i_cnt_byte  in  2  byte index of current serial shift-out (count bits [4:3])
- o_wb_cyc  out  1  bus request, held until ack/abort
- o_wb_we  out  1  registered copy of i_we
- o_wb_sel  out  4  registered byte selects
- i_wb_ack  in  1  bus acknowledge
- o_load  out  1  one-cycle strobe: latch i_wb_rdt into buffer register
- o_byte_valid  out  1  current shift-out byte is inside the access size
- o_busy  out  1  high in BUS and DONE
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  one-cycle trap pulse, no bus cycle issued
- o_timeout  out  1  one-cycle abort pulse (tied 0 when feature off)

## Operation
- States: IDLE, BUS, DONE. Encoding in shared package.
- IDLE: on i_req, latch we/size/lsb. Misaligned (half with lsb[0]=1, word with lsb!=0) -> pulse o_misalign, stay IDLE. Else -> BUS with o_wb_cyc=1.
- o_wb_sel: byte = 4'b0001<<lsb; half = 4'b0011<<{lsb[1],1'b0}; word = 4'b1111. Held constant throughout BUS.
- BUS: i_wb_ack -> cyc=0; if load, o_load=1 for that edge's following cycle; -> DONE.
- DONE: o_done=1 one cycle -> IDLE.
- i_wb_ack outside BUS ignored. i_req outside IDLE ignored (no queuing).
- o_byte_valid (combinational, from latched size): byte: i_cnt_byte==0; half: i_cnt_byte<=1; word: always 1.
- Reset (any state, incl. mid-BUS): immediately returns IDLE; cyc, load, done, misalign, timeout, busy, wb_sel, wb_we all 0.

## Timing
- Request at edge N (IDLE): o_wb_cyc high from N+1. Misalign pulse during cycle N+1.
- Ack sampled at edge M (BUS): cyc low, o_load high during M+1; state DONE during M+1; o_done high during M+2; IDLE from M+2 edge, ready to accept i_req at edge M+2.
- Minimum load/store latency request->o_done: 3 cycles with ack on first bus cycle.
- o_busy = state != IDLE, registered-state-derived, no combinational path from inputs.

## Configuration
- SERV_MEM_SEQ_TIMEOUT_EN defined: 16-bit down-counter loaded with TIMEOUT_CYCLES on BUS entry, decrements each BUS cycle without ack; reaching 0 without ack -> cyc=0, o_timeout pulse, -> IDLE (no o_done, no o_load). Ack on the same cycle as count 0 wins (normal completion).
- Undefined: no counter; BUS waits indefinitely; o_timeout constant 0.

## Structure
- Shared package: state enum (IDLE/BUS/DONE), size codes (SIZE_B/H/W), width constant for timeout counter.
- Single module; timeout counter as optional sub-module serv_mem_seq_tmo (load, enable, expired) instantiated only under the macro.

## Test plan
- Word load lsb=0, ack after 2 wait cycles -> sel=1111, cyc 3 cycles, one o_load pulse, o_done 2 cycles after ack.
- Byte store lsb=3 -> sel=1000, we=1, no o_load, o_done; o_byte_valid high only for i_cnt_byte=0.
- Half load lsb=1 -> o_misalign pulse, cyc never rises; word lsb=2 likewise.
- Assert i_rst while cyc high and before ack -> cyc/busy drop without clock edge; late ack ignored; next req works.
- Timeout enabled, TIMEOUT_CYCLES=4, never ack -> o_timeout after 4 BUS cycles, no o_done; with ack on 4th cycle -> normal o_done.
